// File: rtl/stack_pkg.sv
// Shared encodings and sizing constants for the CPU data-stack controller.
package stack_pkg;

  localparam int unsigned STACK_ADDR_W = 8;
  localparam int unsigned STACK_DATA_W = 32;
  localparam int unsigned STACK_CELLS  = 2 ** STACK_ADDR_W;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_RD_ADDR = 2'd2;
  localparam logic [1:0] ST_RD_CAP  = 2'd3;

endpackage

// File: rtl/stack_ram.sv
// Single-port stack RAM with registered read data; contents are never reset.
module stack_ram
  import stack_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = STACK_ADDR_W,
  parameter int unsigned DATA_WIDTH = STACK_DATA_W
) (
  input  logic                  CLK,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned CELLS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [CELLS];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/stack_ctrl.sv
// Data-stack sequencer: owns sp and the TOS register, and turns push/pop/replace
// commands into timed RAM write and read cycles behind a ready/valid handshake.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = STACK_ADDR_W,
  parameter int unsigned DATA_WIDTH = STACK_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic [DATA_WIDTH-1:0] tos,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  err_overflow,
  output logic                  err_underflow,
  input  logic                  err_clr
);

  localparam int unsigned CELLS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH_FULL = (ADDR_WIDTH + 1)'(CELLS + 1);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [DATA_WIDTH-1:0] tos_nxt;
  logic [ADDR_WIDTH:0]   depth_nxt;
  logic [ADDR_WIDTH:0]   sp_q;
  logic [ADDR_WIDTH:0]   sp_nxt;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ram_we;
  logic                  ovf_set;
  logic                  unf_set;
  logic                  accept;

  // cmd_ready is a registered copy of (state == ST_IDLE)
  assign accept = cmd_valid && cmd_ready;

  stack_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tos_nxt   = tos;
    depth_nxt = depth;
    sp_nxt    = sp_q;
    addr_nxt  = ram_addr;
    wdata_nxt = ram_wdata;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (stack_op_e'(cmd_op))
            OP_PUSH: begin
              if (depth == '0) begin
                tos_nxt   = cmd_data;
                depth_nxt = DEPTH_ONE;
              end else if (depth == DEPTH_FULL) begin
                ovf_set = 1'b1;
              end else begin
                // Old TOS spills to RAM[sp] on the following edge
                wdata_nxt = tos;
                addr_nxt  = sp_q[ADDR_WIDTH-1:0];
                tos_nxt   = cmd_data;
                depth_nxt = depth + DEPTH_ONE;
                state_nxt = ST_WRITE;
              end
            end
            OP_POP: begin
              if (depth == '0) begin
                unf_set = 1'b1;
              end else if (depth == DEPTH_ONE) begin
                tos_nxt   = '0;
                depth_nxt = '0;
              end else begin
                addr_nxt  = ADDR_WIDTH'(sp_q - DEPTH_ONE);
                sp_nxt    = sp_q - DEPTH_ONE;
                depth_nxt = depth - DEPTH_ONE;
                state_nxt = ST_RD_ADDR;
              end
            end
            OP_REPLACE: begin
              tos_nxt = cmd_data;
              if (depth == '0) begin
                depth_nxt = DEPTH_ONE;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WRITE: begin
        sp_nxt    = sp_q + DEPTH_ONE;
        state_nxt = ST_IDLE;
      end
      ST_RD_ADDR: begin
        state_nxt = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        tos_nxt   = ram_rdata;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers; error set wins over a same-cycle clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      tos           <= '0;
      depth         <= '0;
      sp_q          <= '0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      ram_we        <= 1'b0;
      cmd_ready     <= 1'b1;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      tos           <= tos_nxt;
      depth         <= depth_nxt;
      sp_q          <= sp_nxt;
      ram_addr      <= addr_nxt;
      ram_wdata     <= wdata_nxt;
      ram_we        <= (state_nxt == ST_WRITE);
      cmd_ready     <= (state_nxt == ST_IDLE);
      err_overflow  <= ovf_set | (err_overflow & ~err_clr);
      err_underflow <= unf_set | (err_underflow & ~err_clr);
    end
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencing controller for the CPU data stack: owns the stack pointer and the top-of-stack (TOS) register, and the 256x32 synchronous-read stack RAM behind them.
- Turns single push/pop/replace commands into correctly timed RAM write and read cycles.
- Sits between the instruction-phase sequencer in top and the stack RAM.
- Replaces hand-coded write pulses and fixed "fluffy wait" phases with one ready/valid handshake plus depth and error tracking.

Parameters:
- ADDR_WIDTH, 8, RAM address bits; RAM holds 2**ADDR_WIDTH cells.
- DATA_WIDTH, 32, stack cell width.

Ports:
- CLK, in, 1, system clock (16 MHz).
- RST, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, controller idle; command accepted on the edge where cmd_valid && cmd_ready.
- cmd_op, in, 2, operation: NOP / PUSH / POP / REPLACE.
- cmd_data, in, DATA_WIDTH, new TOS value for PUSH and REPLACE.
- tos, out, DATA_WIDTH, current top-of-stack value.
- depth, out, ADDR_WIDTH+1, live entries including TOS (0 .. 2**ADDR_WIDTH+1).
- err_overflow, out, 1, sticky; set by PUSH at full depth.
- err_underflow, out, 1, sticky; set by POP at depth 0.
- err_clr, in, 1, clears both sticky error flags.

Behaviour:
- Reset:
  - Synchronous, active-high, on CLK only.
  - Reset values: tos=0, depth=0, sp=0, state=IDLE, cmd_ready=1, both error flags 0, RAM write-enable 0.
  - RST overrides everything, including mid-operation: any in-flight write or read is abandoned.
  - RAM contents are not cleared.
- Stack model: TOS lives in a register. RAM[0..sp-1] hold deeper entries. depth = sp + (depth!=0).
- States: IDLE, WRITE, RD_ADDR, RD_CAP.
- cmd_ready = (state==IDLE). It is a pure decode, never combinationally dependent on cmd_valid.
- NOP: accepted, no effect, stays IDLE.
- REPLACE:
  - tos <= cmd_data on the accept edge; stays IDLE.
  - Depth 0: depth becomes 1.
- PUSH, depth 0: tos <= cmd_data, depth <= 1, no RAM access, stays IDLE.
- PUSH, 1 <= depth <= 2**ADDR_WIDTH:
  - Accept edge N: latch wdata <= old tos, addr <= sp; tos <= cmd_data; depth++; go to WRITE.
  - Edge N+1: we=1, RAM written; sp++; go to IDLE.
  - cmd_ready is low for exactly one cycle; next accept at the earliest at edge N+2.
- PUSH at depth == 2**ADDR_WIDTH+1:
  - Command is consumed; err_overflow <= 1.
  - tos, depth and RAM unchanged; stays IDLE.
- POP, depth 1: tos <= 0, depth <= 0, no RAM access, stays IDLE.
- POP, depth >= 2:
  - Accept edge N: addr <= sp-1; sp--; depth--; go to RD_ADDR.
  - Edge N+1: RAM samples addr; go to RD_CAP.
  - Edge N+2: tos <= rdata; go to IDLE.
  - New tos is visible from edge N+2; cmd_ready is low for 2 cycles.
- POP at depth 0: command consumed; err_underflow <= 1; no other change.
- Address arithmetic is ADDR_WIDTH-bit. sp cannot wrap because the full and empty guards above prevent it.
- Sticky error flags:
  - err_clr and a new error in the same cycle: the flag is set (set wins).
  - err_clr while busy is honoured immediately.
- cmd_op and cmd_data are ignored when no accept occurs.
- The RAM write-enable is asserted only in WRITE, for exactly one cycle.

Decomposition:
- Package stack_pkg holds:
  - the op encoding: NOP=2'b00, PUSH=2'b01, POP=2'b10, REPLACE=2'b11;
  - the state encoding;
  - the constant STACK_CELLS = 2**ADDR_WIDTH.
- One sub-module: stack_ram, the single-port synchronous RAM (registered dout, write-enable, ADDR_WIDTH x DATA_WIDTH), instantiated once inside stack_ctrl.

Test Plan:
- Reset, then PUSH 0x11, PUSH 0x22, PUSH 0x33 -> tos=0x33, depth=3, RAM[0]=0x11, RAM[1]=0x22; cmd_ready low for 1 cycle after the 2nd and 3rd pushes only.
- From that state, POP, POP, POP -> tos reads 0x22 two edges after the first accept, then 0x11, then 0; depth 2,1,0; cmd_ready low 2,2,0 cycles.
- POP at depth 0 -> err_underflow=1, depth stays 0; then err_clr -> flag 0. Push 257 values 1..257, then PUSH 0x999 -> err_overflow=1, tos=257, depth=257.
- Back-to-back cmd_valid held high alternating PUSH 0xA5 / POP at depth 5 -> each accept only when cmd_ready=1; final depth 5 and tos unchanged.
- REPLACE 0xDEAD at depth 0 -> depth 1, tos=0xDEAD, no RAM write; at depth 4 -> only tos changes.
- RST asserted in RD_ADDR of a POP from depth 3 -> next cycle tos=0, depth=0, cmd_ready=1, flags 0, no write-enable pulse.
